// File: rtl/uart_bus_master.sv
// uart_bus_master
// UART-driven bus initiator for debug/boot. Parses command frames arriving
// from uart_rx and issues 32-bit word loads/stores on the load/store bus, then
// replies over uart_tx.
//   'W' A0..A3 D0..D3 -> store word, reply 'K'
//   'R' A0..A3        -> load word, reply B0..B3 (LSB first)
//   anything else     -> reply '?'
// Ports:
//   clk, rst                      clock, async active-high reset
//   rx_byte, rx_byte_ready        received byte + one-cycle valid pulse
//   tx_byte, tx_en, tx_ready      byte to transmit, start pulse, transmitter idle
//   bus_address, bus_wdata        word address (bits[1:0] = 0), store data
//   bus_rdata, bus_ack            load data, transfer-complete strobe
//   bus_load_enable/store_enable  requests, held until bus_ack
//   busy                          state != IDLE
//   overrun                       sticky: byte arrived during BUS/RESP
// Optional feature: define DBG_TIMEOUT_EN to abort a frame whose bytes are
// more than TIMEOUT_CYCLES apart (reply '?').
//
// state  | meaning
// IDLE   | waiting for command byte
// ADDR   | shifting in 4 address bytes
// DATA   | shifting in 4 store-data bytes ('W' only)
// BUS    | issuing the load/store, waiting for bus_ack
// RESP   | sending reply bytes over uart_tx

module uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_en,
    input  logic        tx_ready,
    output logic [31:0] bus_address,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        bus_load_enable,
    output logic        bus_store_enable,
    input  logic        bus_ack,
    output logic        busy,
    output logic        overrun
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_BUS  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [1:0] TX_SEND    = 2'd0;
    localparam logic [1:0] TX_WAIT_LO = 2'd1;
    localparam logic [1:0] TX_WAIT_HI = 2'd2;

    logic [2:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] resp_q, resp_d;
    logic [1:0]  resp_left_q, resp_left_d;
    logic        issued_q, issued_d;
    logic        load_en_q, load_en_d;
    logic        store_en_q, store_en_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_en_q, tx_en_d;
    logic [1:0]  tx_ph_q, tx_ph_d;
    logic        overrun_q, overrun_d;

`ifdef DBG_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    logic unused_timeout_param;
    assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_d      = resp_q;
        resp_left_d = resp_left_q;
        issued_d    = issued_q;
        load_en_d   = load_en_q;
        store_en_d  = store_en_q;
        tx_byte_d   = tx_byte_q;
        tx_en_d     = 1'b0;
        tx_ph_d     = tx_ph_q;
        overrun_d   = overrun_q;

        // Bytes arriving while the bus or the reply is in flight are dropped.
        if (rx_byte_ready && (state_q == S_BUS || state_q == S_RESP))
            overrun_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (rx_byte_ready) begin
                    cnt_d = 2'd0;
                    if (rx_byte == 8'h57) begin
                        is_wr_d = 1'b1;
                        state_d = S_ADDR;
                    end else if (rx_byte == 8'h52) begin
                        is_wr_d = 1'b0;
                        state_d = S_ADDR;
                    end else begin
                        resp_d      = 32'h0000_003F;
                        resp_left_d = 2'd0;
                        tx_ph_d     = TX_SEND;
                        state_d     = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_byte_ready) begin
                    addr_d = {rx_byte, addr_q[31:8]};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        issued_d = 1'b0;
                        state_d  = is_wr_q ? S_DATA : S_BUS;
                    end
                end
            end
            S_DATA: begin
                if (rx_byte_ready) begin
                    wdata_d = {rx_byte, wdata_q[31:8]};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        issued_d = 1'b0;
                        state_d  = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // First BUS cycle only arms the request; it is visible one cycle later.
                if (!issued_q) begin
                    issued_d = 1'b1;
                    if (is_wr_q) store_en_d = 1'b1;
                    else         load_en_d  = 1'b1;
                end else if ((load_en_q || store_en_q) && bus_ack) begin
                    load_en_d   = 1'b0;
                    store_en_d  = 1'b0;
                    resp_d      = is_wr_q ? 32'h0000_004B : bus_rdata;
                    resp_left_d = is_wr_q ? 2'd0 : 2'd3;
                    tx_ph_d     = TX_SEND;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                case (tx_ph_q)
                    TX_SEND: begin
                        if (tx_ready) begin
                            tx_en_d   = 1'b1;
                            tx_byte_d = resp_q[7:0];
                            tx_ph_d   = TX_WAIT_LO;
                        end
                    end
                    TX_WAIT_LO: begin
                        if (!tx_ready) tx_ph_d = TX_WAIT_HI;
                    end
                    TX_WAIT_HI: begin
                        if (tx_ready) begin
                            if (resp_left_q == 2'd0) begin
                                state_d = S_IDLE;
                            end else begin
                                resp_d      = resp_q >> 8;
                                resp_left_d = resp_left_q - 2'd1;
                                tx_ph_d     = TX_SEND;
                            end
                        end
                    end
                    default: tx_ph_d = TX_SEND;
                endcase
            end
            default: state_d = S_IDLE;
        endcase

`ifdef DBG_TIMEOUT_EN
        tmo_d = '0;
        if ((state_q == S_ADDR || state_q == S_DATA) && !rx_byte_ready) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
                resp_d      = 32'h0000_003F;
                resp_left_d = 2'd0;
                tx_ph_d     = TX_SEND;
                state_d     = S_RESP;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            is_wr_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            resp_q      <= 32'd0;
            resp_left_q <= 2'd0;
            issued_q    <= 1'b0;
            load_en_q   <= 1'b0;
            store_en_q  <= 1'b0;
            tx_byte_q   <= 8'd0;
            tx_en_q     <= 1'b0;
            tx_ph_q     <= TX_SEND;
            overrun_q   <= 1'b0;
`ifdef DBG_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_q      <= resp_d;
            resp_left_q <= resp_left_d;
            issued_q    <= issued_d;
            load_en_q   <= load_en_d;
            store_en_q  <= store_en_d;
            tx_byte_q   <= tx_byte_d;
            tx_en_q     <= tx_en_d;
            tx_ph_q     <= tx_ph_d;
            overrun_q   <= overrun_d;
`ifdef DBG_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign bus_address      = addr_q & 32'hFFFF_FFFC;
    assign bus_wdata        = wdata_q;
    assign bus_load_enable  = load_en_q;
    assign bus_store_enable = store_en_q;
    assign tx_byte          = tx_byte_q;
    assign tx_en            = tx_en_q;
    assign busy             = (state_q != S_IDLE);
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_uart_bus_master.sv
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = 8'd0;
    logic        rx_byte_ready = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_en;
    logic        tx_ready = 1'b1;
    logic [31:0] bus_address;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_load_enable;
    logic        bus_store_enable;
    logic        bus_ack = 1'b0;
    logic        busy;
    logic        overrun;

    uart_bus_master #(.TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst(rst),
        .rx_byte(rx_byte), .rx_byte_ready(rx_byte_ready),
        .tx_byte(tx_byte), .tx_en(tx_en), .tx_ready(tx_ready),
        .bus_address(bus_address), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_load_enable(bus_load_enable), .bus_store_enable(bus_store_enable),
        .bus_ack(bus_ack), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder model: acks ack_delay cycles after the request appears.
    int          ack_delay = 0;
    logic [31:0] rdata_val = 32'd0;
    int          bus_reqs = 0;
    int          en_cycles = 0;
    int          wait_cnt = 0;
    int          ack_cyc = 0;
    bit          in_txn = 0;
    bit          ack_done = 0;
    bit          addr_unstable = 0;
    logic [31:0] log_addr = 32'd0;
    logic [31:0] log_wdata = 32'd0;
    bit          log_store = 0;

    always @(negedge clk) begin
        bus_ack = 1'b0;
        if (bus_load_enable || bus_store_enable) begin
            if (!in_txn) begin
                in_txn = 1; en_cycles = 0; wait_cnt = 0; ack_done = 0; addr_unstable = 0;
                bus_reqs++;
                log_addr = bus_address; log_wdata = bus_wdata; log_store = bus_store_enable;
            end
            en_cycles++;
            if (bus_address !== log_addr || bus_wdata !== log_wdata) addr_unstable = 1;
            if (!ack_done) begin
                if (wait_cnt == ack_delay) begin
                    bus_ack = 1'b1; bus_rdata = rdata_val; ack_done = 1; ack_cyc = cyc;
                end else begin
                    wait_cnt++;
                end
            end
        end else begin
            in_txn = 0;
        end
    end

    // Transmitter model: goes busy for 3 cycles after each tx_en.
    logic [7:0] tx_log [0:63];
    int         tx_cyc [0:63];
    int         tx_n = 0;
    int         tx_busy = 0;

    always @(negedge clk) begin
        if (tx_en) begin
            tx_log[tx_n % 64] = tx_byte;
            tx_cyc[tx_n % 64] = cyc;
            tx_n++;
            tx_ready = 1'b0;
            tx_busy = 3;
        end else if (tx_busy > 0) begin
            tx_busy--;
            if (tx_busy == 0) tx_ready = 1'b1;
        end
    end

    logic [7:0] fr [9];
    int base_r, base_t;
    logic [31:0] word;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        rx_byte_ready = 1'b1;
        @(negedge clk);
        rx_byte_ready = 1'b0;
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) send_byte(fr[i]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", name, busy, n);
        end
    endtask

    task automatic wait_enable(input string name);
        int n = 0;
        while (!(bus_load_enable || bus_store_enable) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(bus_load_enable || bus_store_enable)) begin
            failures++;
            $display("FAIL %s_enable: no bus request after %0d cycles, want one", name, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_byte, bus_address, bus_wdata} !== 72'd0) begin
            failures++;
            $display("FAIL reset_data: tx_byte=%h addr=%h wdata=%h want 0", tx_byte, bus_address, bus_wdata);
        end
        checks++;
        if ({tx_en, bus_load_enable, bus_store_enable, busy, overrun} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: tx_en/ld/st/busy/ovr=%b want 00000",
                     {tx_en, bus_load_enable, bus_store_enable, busy, overrun});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_store();
        base_r = bus_reqs; base_t = tx_n; ack_delay = 3;
        fr = '{8'h57, 8'h00, 8'h20, 8'h03, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frame(9);
        wait_idle("store");
        checks++;
        if (bus_reqs - base_r != 1 || log_store != 1) begin
            failures++;
            $display("FAIL store_req: reqs=%0d store=%0d want 1 1", bus_reqs - base_r, log_store);
        end
        checks++;
        if (log_addr !== 32'h00032000) begin
            failures++; $display("FAIL store_addr: got %h want 00032000", log_addr);
        end
        checks++;
        if (log_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL store_wdata: got %h want deadbeef", log_wdata);
        end
        checks++;
        if (en_cycles != 4 || addr_unstable) begin
            failures++;
            $display("FAIL store_hold: enable cycles=%0d unstable=%0d want 4 0", en_cycles, addr_unstable);
        end
        checks++;
        if (tx_n - base_t != 1 || tx_log[base_t % 64] !== 8'h4B) begin
            failures++;
            $display("FAIL store_reply: count=%0d byte=%h want 1 4b", tx_n - base_t, tx_log[base_t % 64]);
        end
        checks++;
        if (tx_cyc[base_t % 64] - ack_cyc < 2) begin
            failures++;
            $display("FAIL store_latency: tx_en %0d cycles after ack, want >=2", tx_cyc[base_t % 64] - ack_cyc);
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++; $display("FAIL store_overrun: got %b want 0", overrun);
        end
    endtask

    task automatic test_load();
        base_r = bus_reqs; base_t = tx_n; ack_delay = 0; rdata_val = 32'h00000001;
        fr = '{8'h52, 8'h08, 8'h20, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(5);
        wait_idle("load");
        checks++;
        if (bus_reqs - base_r != 1 || log_store != 0 || log_addr !== 32'h00032008) begin
            failures++;
            $display("FAIL load_req: reqs=%0d store=%0d addr=%h want 1 0 00032008",
                     bus_reqs - base_r, log_store, log_addr);
        end
        checks++;
        if (tx_n - base_t != 4) begin
            failures++; $display("FAIL load_count: got %0d bytes want 4", tx_n - base_t);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_log[(base_t + i) % 64] !== ((i == 0) ? 8'h01 : 8'h00)) begin
                failures++;
                $display("FAIL load_byte%0d: got %h want %h", i, tx_log[(base_t + i) % 64],
                         (i == 0) ? 8'h01 : 8'h00);
            end
        end
    endtask

    task automatic test_mask_and_bad();
        base_r = bus_reqs; base_t = tx_n; ack_delay = 1; rdata_val = 32'hA1B2C3D4;
        fr = '{8'h52, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(5);
        wait_idle("mask");
        checks++;
        if (log_addr !== 32'h00000000) begin
            failures++; $display("FAIL mask_addr: got %h want 00000000", log_addr);
        end
        word = {tx_log[(base_t + 3) % 64], tx_log[(base_t + 2) % 64],
                tx_log[(base_t + 1) % 64], tx_log[base_t % 64]};
        checks++;
        if (tx_n - base_t != 4 || word !== 32'hA1B2C3D4) begin
            failures++;
            $display("FAIL mask_reply: count=%0d word=%h want 4 a1b2c3d4", tx_n - base_t, word);
        end
        base_r = bus_reqs; base_t = tx_n;
        fr[0] = 8'h41;
        send_frame(1);
        wait_idle("bad");
        checks++;
        if (bus_reqs != base_r || tx_n - base_t != 1 || tx_log[base_t % 64] !== 8'h3F) begin
            failures++;
            $display("FAIL bad_cmd: reqs=%0d count=%0d byte=%h want 0 1 3f",
                     bus_reqs - base_r, tx_n - base_t, tx_log[base_t % 64]);
        end
    endtask

    task automatic test_overrun();
        base_r = bus_reqs; base_t = tx_n; ack_delay = 10; rdata_val = 32'h11223344;
        fr = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(5);
        wait_enable("overrun");
        send_byte(8'h57);
        wait_idle("overrun");
        word = {tx_log[(base_t + 3) % 64], tx_log[(base_t + 2) % 64],
                tx_log[(base_t + 1) % 64], tx_log[base_t % 64]};
        checks++;
        if (overrun !== 1'b1) begin
            failures++; $display("FAIL overrun_flag: got %b want 1", overrun);
        end
        checks++;
        if (bus_reqs - base_r != 1 || log_addr !== 32'h10 || tx_n - base_t != 4 || word !== 32'h11223344) begin
            failures++;
            $display("FAIL overrun_frame: reqs=%0d addr=%h count=%0d word=%h want 1 00000010 4 11223344",
                     bus_reqs - base_r, log_addr, tx_n - base_t, word);
        end
        base_r = bus_reqs; base_t = tx_n; ack_delay = 1;
        fr = '{8'h57, 8'h20, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        send_frame(9);
        wait_idle("after_overrun");
        checks++;
        if (bus_reqs - base_r != 1 || log_store != 1 || log_addr !== 32'h20 || log_wdata !== 32'h1
            || tx_log[base_t % 64] !== 8'h4B || overrun !== 1'b1) begin
            failures++;
            $display("FAIL after_overrun: reqs=%0d st=%0d addr=%h wdata=%h tx=%h ovr=%b want 1 1 20 1 4b 1",
                     bus_reqs - base_r, log_store, log_addr, log_wdata, tx_log[base_t % 64], overrun);
        end
    endtask

    task automatic test_rst_midframe();
        fr = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0 || bus_store_enable !== 1'b0) begin
            failures++;
            $display("FAIL rst_addr: busy=%b ovr=%b st=%b want 0 0 0", busy, overrun, bus_store_enable);
        end
        @(negedge clk);
        rst = 1'b0;
        ack_delay = 30;
        fr = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(5);
        wait_enable("rst_bus");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus_load_enable !== 1'b0 || busy !== 1'b0 || tx_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_bus: ld=%b busy=%b tx_en=%b want 0 0 0", bus_load_enable, busy, tx_en);
        end
        @(negedge clk);
        rst = 1'b0;
        base_r = bus_reqs; base_t = tx_n; ack_delay = 2;
        fr = '{8'h57, 8'h04, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_frame(9);
        wait_idle("rst_recover");
        checks++;
        if (bus_reqs - base_r != 1 || log_store != 1 || log_addr !== 32'h4 || log_wdata !== 32'h12345678) begin
            failures++;
            $display("FAIL rst_recover_bus: reqs=%0d st=%0d addr=%h wdata=%h want 1 1 4 12345678",
                     bus_reqs - base_r, log_store, log_addr, log_wdata);
        end
        checks++;
        if (tx_n - base_t != 1 || tx_log[base_t % 64] !== 8'h4B) begin
            failures++;
            $display("FAIL rst_recover_reply: count=%0d byte=%h want 1 4b", tx_n - base_t, tx_log[base_t % 64]);
        end
    endtask

`ifdef DBG_TIMEOUT_EN
    task automatic test_timeout();
        base_r = bus_reqs; base_t = tx_n;
        fr = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(2);
        repeat (60) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus_reqs != base_r || tx_n - base_t != 1 || tx_log[base_t % 64] !== 8'h3F) begin
            failures++;
            $display("FAIL timeout: busy=%b reqs=%0d count=%0d byte=%h want 0 0 1 3f",
                     busy, bus_reqs - base_r, tx_n - base_t, tx_log[base_t % 64]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_store();
        test_load();
        test_mask_and_bad();
        test_overrun();
        test_rst_midframe();
`ifdef DBG_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
